button_event_gen: RTL and testbench
===================================

// Module: button_event_gen
// PURPOSE
//  Consumes the debounced, clk-synchronous button levels from the debounce stage.
//  Turns each level into single-cycle game events: press, short press, long press,
//  release and optional auto-repeat. Events go to the game controller FSM.
//  Targets a 100 MHz Nexys A7. One instance serves all NUM_BTN buttons.
// PARAMETERS
//  NUM_BTN    5            number of button channels
//  CLK_HZ     100_000_000  clk frequency; sets the 1 ms prescaler terminal count
//  LONG_MS    500          hold time in ms ticks before long_pulse
//  REPEAT_MS  100          ms ticks between repeat_pulse while held (AUTO_REPEAT_EN only)
// PORTS
//  clk           in   1        system clock, all logic posedge
//  reset_n       in   1        asynchronous, active-low reset
//  enable        in   1        0 = forces all channels to IDLE and suppresses all events
//  btn_in        in   NUM_BTN  debounced levels, already synchronous to clk
//  press_pulse   out  NUM_BTN  1-cycle pulse on a rising level
//  short_pulse   out  NUM_BTN  1-cycle pulse on release before the long threshold
//  long_pulse    out  NUM_BTN  1-cycle pulse when a hold reaches LONG_MS
//  release_pulse out  NUM_BTN  1-cycle pulse on any release out of DOWN or HELD
//  repeat_pulse  out  NUM_BTN  1-cycle pulse every REPEAT_MS while in HELD
//  held          out  NUM_BTN  level; 1 while the channel is in HELD
//  any_press     out  1        OR of press_pulse, registered the same cycle as press_pulse
// BEHAVIOUR
//  Reset: every output 0; btn_prev 0; armed 0; every channel IDLE; all counters 0.
//  Arming: on the first clk after reset release, btn_prev <= btn_in, armed <= 1, no events.
//   A button held through reset therefore produces no press until it is released and pressed again.
//  Prescaler: free-running 0..CLK_HZ/1000-1; ms_tick=1 for one cycle at terminal count.
//  Per-channel FSM. rise = btn_in & ~btn_prev. fall = ~btn_in & btn_prev.
//   IDLE: on rise -> DOWN, press_pulse, ms_cnt <= 0.
//   DOWN: on fall -> IDLE, short_pulse + release_pulse.
//         Otherwise ms_cnt++ on each ms_tick; when ms_cnt reaches LONG_MS -> HELD, long_pulse, ms_cnt <= 0.
//   HELD: on fall -> IDLE, release_pulse. Otherwise behaves per CONFIGURATION.
//  All event outputs are registered: 1-cycle latency from the clk edge that samples the btn_in change.
//  Simultaneous fall and LONG threshold in DOWN: the fall wins (short_pulse, no long_pulse).
//  Simultaneous fall and repeat in HELD: release only, no repeat_pulse.
//  Pulse exclusivity per channel per cycle: at most one of press/short/long/repeat, except
//   short+release. Channels are fully independent; simultaneous events on several channels are legal.
//  ms_cnt width = $clog2(max(LONG_MS,REPEAT_MS)+1). It saturates and never wraps.
//  enable=0: channels go to IDLE next cycle, counters clear, outputs 0. btn_prev keeps tracking,
//   so a button held while enable rises produces no event.
//  Long threshold latency is LONG_MS-1 to LONG_MS ms, due to prescaler phase. This is accepted.
//  Reset asserted mid-hold: immediate return to reset state; no release_pulse.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: HELD counts ms_tick; at REPEAT_MS it emits repeat_pulse and ms_cnt <= 0.
//  AUTO_REPEAT_EN undefined: the HELD counter is not built; repeat_pulse tied 0. All else identical.
// STRUCTURE
//  Package btn_event_pkg: btn_state_e {IDLE, DOWN, HELD}, MS_DIV function (CLK_HZ/1000), cnt width function.
//  Sub-module btn_event_fsm: one channel (state, ms_cnt, registered pulses).
//   The top holds the prescaler, btn_prev, armed and the NUM_BTN generate loop, and ORs any_press.
// TESTING (bench params CLK_HZ=10_000 so ms_tick every 10 clk; LONG_MS=5; REPEAT_MS=2)
//  1. btn_in[0] 0->1, held 20 clk, ->0
//     -> press_pulse[0] one cycle after the rise; short_pulse[0]+release_pulse[0] together; no long_pulse.
//  2. btn_in[1] held 120 clk -> long_pulse[1] after 5 ticks; held[1]=1.
//     With AUTO_REPEAT_EN: repeat_pulse[1] every 20 clk. Without: none.
//     Release -> release_pulse only.
//  3. btn_in[2] high through reset release -> no press_pulse.
//     Release, then press again -> exactly one press_pulse[2].
//  4. Fall in the same cycle as the 5th tick in DOWN -> short_pulse, no long_pulse.
//     Buttons 0 and 3 rise together -> both press_pulse bits and any_press in the same cycle.
//  5. enable=0 mid-HELD -> held drops next cycle, no pulses; enable=1 with button still high -> no events.
//  6. reset_n low mid-hold -> all outputs 0 asynchronously; no release_pulse after reset_n returns high.

Source files
------------

// File: rtl/btn_event_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : btn_event_pkg
//  Brief   : Shared types and sizing helpers for the button event generator.
//  Revision: 1.0  initial release
// ============================================================================
package btn_event_pkg;

  // Per-channel press lifecycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    HELD = 2'd2
  } btn_state_e;

  // Clock cycles per 1 ms tick, never below one
  function automatic int ms_div(input int clk_hz);
    return (clk_hz / 1000 < 1) ? 1 : clk_hz / 1000;
  endfunction

  // Width of the ms counter so it can hold the larger of the two thresholds
  function automatic int cnt_width(input int long_ms, input int repeat_ms);
    int m;
    m = (long_ms > repeat_ms) ? long_ms : repeat_ms;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_event_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : btn_event_fsm
//  Brief   : One button channel: IDLE/DOWN/HELD lifecycle, ms hold counter
//            and registered single-cycle event pulses.
//            AUTO_REPEAT_EN builds the HELD repeat counter; otherwise
//            repeat_pulse is tied low.
//  Revision: 1.0  initial release
// ============================================================================
module btn_event_fsm
  import btn_event_pkg::*;
#(
  parameter int LONG_MS   = 500,
`ifdef AUTO_REPEAT_EN
  parameter int REPEAT_MS = 100,
`endif
  parameter int CNT_W     = 9
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic rise,
  input  logic fall,
  input  logic ms_tick,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic held,
  output logic press_next
);

  localparam logic [CNT_W-1:0] c_LONG = CNT_W'(LONG_MS);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] c_REPEAT = CNT_W'(REPEAT_MS);
`endif

  btn_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             w_press, w_short, w_long, w_release;
  logic             r_press, r_short, r_long, r_release;
`ifdef AUTO_REPEAT_EN
  logic             w_repeat, r_repeat;
`endif

  // Counter increments saturate rather than wrap
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  // State and ms counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter update; a release always beats a threshold
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (rise) begin
            w_state_nxt = DOWN;
            w_cnt_nxt   = '0;
          end
        end
        DOWN: begin
          if (fall) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (ms_tick) begin
            if (w_cnt_inc == c_LONG) begin
              w_state_nxt = HELD;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        HELD: begin
          if (fall) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
`ifdef AUTO_REPEAT_EN
          else if (ms_tick) begin
            w_cnt_nxt = (w_cnt_inc == c_REPEAT) ? '0 : w_cnt_inc;
          end
`endif
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Event decode for the coming cycle; everything is silent while disabled
  always_comb begin
    w_press   = 1'b0;
    w_short   = 1'b0;
    w_long    = 1'b0;
    w_release = 1'b0;
`ifdef AUTO_REPEAT_EN
    w_repeat  = 1'b0;
`endif
    if (enable) begin
      case (r_state)
        IDLE: w_press = rise;
        DOWN: begin
          if (fall) begin
            w_short   = 1'b1;
            w_release = 1'b1;
          end else if (ms_tick && (w_cnt_inc == c_LONG)) begin
            w_long = 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            w_release = 1'b1;
          end
`ifdef AUTO_REPEAT_EN
          else if (ms_tick && (w_cnt_inc == c_REPEAT)) begin
            w_repeat = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Registered event pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_press   <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_release <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_repeat  <= 1'b0;
`endif
    end else begin
      r_press   <= w_press;
      r_short   <= w_short;
      r_long    <= w_long;
      r_release <= w_release;
`ifdef AUTO_REPEAT_EN
      r_repeat  <= w_repeat;
`endif
    end
  end

  assign press_pulse   = r_press;
  assign short_pulse   = r_short;
  assign long_pulse    = r_long;
  assign release_pulse = r_release;
`ifdef AUTO_REPEAT_EN
  assign repeat_pulse  = r_repeat;
`else
  assign repeat_pulse  = 1'b0;
`endif
  assign held          = (r_state == HELD);
  assign press_next    = w_press;

endmodule
`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// ============================================================================
//  Module  : button_event_gen
//  Brief   : Turns debounced button levels into single-cycle press, short,
//            long, release and (with AUTO_REPEAT_EN) repeat events.
//            Holds the shared 1 ms prescaler, edge history and arming flag.
//  Revision: 1.0  initial release
// ============================================================================
module button_event_gen
  import btn_event_pkg::*;
#(
  parameter int NUM_BTN   = 5,
  parameter int CLK_HZ    = 100_000_000,
  parameter int LONG_MS   = 500,
  parameter int REPEAT_MS = 100
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] short_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse,
  output logic [NUM_BTN-1:0] held,
  output logic               any_press
);

  localparam int c_MS_DIV = ms_div(CLK_HZ);
  localparam int c_PRE_W  = (c_MS_DIV > 1) ? $clog2(c_MS_DIV) : 1;
  localparam int c_CNT_W  = cnt_width(LONG_MS, REPEAT_MS);
  localparam logic [c_PRE_W-1:0] c_PRE_TC = c_PRE_W'(c_MS_DIV - 1);

  logic [c_PRE_W-1:0] r_pre;
  logic               w_ms_tick;
  logic [NUM_BTN-1:0] r_btn_prev;
  logic               r_armed;
  logic [NUM_BTN-1:0] w_rise, w_fall, w_press_nxt;
  logic               r_any_press;

  assign w_ms_tick = (r_pre == c_PRE_TC);

  // Free-running 1 ms prescaler
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_pre <= '0;
    else if (w_ms_tick) r_pre <= '0;
    else                r_pre <= r_pre + 1'b1;
  end

  // Edge history; the first cycle after reset only arms, so a button held
  // through reset never reports a press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_prev <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_btn_prev <= btn_in;
      r_armed    <= 1'b1;
    end
  end

  assign w_rise = btn_in & ~r_btn_prev & {NUM_BTN{r_armed}};
  assign w_fall = ~btn_in & r_btn_prev & {NUM_BTN{r_armed}};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_event_fsm #(
      .LONG_MS   (LONG_MS),
`ifdef AUTO_REPEAT_EN
      .REPEAT_MS (REPEAT_MS),
`endif
      .CNT_W     (c_CNT_W)
    ) u_fsm (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .rise          (w_rise[i]),
      .fall          (w_fall[i]),
      .ms_tick       (w_ms_tick),
      .press_pulse   (press_pulse[i]),
      .short_pulse   (short_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .held          (held[i]),
      .press_next    (w_press_nxt[i])
    );
  end

  // Any-press flag registered alongside the per-channel press pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_any_press <= 1'b0;
    else          r_any_press <= |w_press_nxt;
  end

  assign any_press = r_any_press;

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// ============================================================================
//  Module  : tb_button_event_gen
//  Brief   : Self-checking bench for button_event_gen (CLK_HZ=10_000,
//            LONG_MS=5, REPEAT_MS=2). Honours AUTO_REPEAT_EN.
//  Revision: 1.0  initial release
// ============================================================================
module tb_button_event_gen;

  localparam int NB  = 5;
  localparam int DIV = 10;
  localparam int LMS = 5;
  localparam int RMS = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] press_pulse, short_pulse, long_pulse, release_pulse, repeat_pulse, held;
  logic          any_press;

  button_event_gen #(
    .NUM_BTN(NB), .CLK_HZ(10_000), .LONG_MS(LMS), .REPEAT_MS(RMS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .btn_in(btn_in),
    .press_pulse(press_pulse), .short_pulse(short_pulse), .long_pulse(long_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse), .held(held),
    .any_press(any_press)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a channel is "pressed" from its press event until release;
  // ticks counts ms ticks seen while pressed. Events follow from ticks.
  bit            m_pressed [NB];
  int            m_ticks   [NB];
  logic [NB-1:0] m_prev;
  bit            m_armed;
  int            cyc;
  logic [NB-1:0] e_press, e_short, e_long, e_rel, e_rep, e_held;
  int            n_press [NB], n_short [NB], n_long [NB], n_rel [NB], n_rep [NB];

  always @(posedge clk) begin
    bit tick, rise, fall;
    e_press = '0; e_short = '0; e_long = '0; e_rel = '0; e_rep = '0; e_held = '0;
    if (!reset_n) begin
      cyc = 0; m_prev = '0; m_armed = 0;
      for (int c = 0; c < NB; c++) begin m_pressed[c] = 0; m_ticks[c] = 0; end
    end else begin
      cyc++;
      tick = (cyc % DIV == 0);
      for (int c = 0; c < NB; c++) begin
        rise = m_armed && btn_in[c] && !m_prev[c];
        fall = m_armed && !btn_in[c] && m_prev[c];
        if (!enable) begin
          m_pressed[c] = 0;
        end else if (!m_pressed[c]) begin
          if (rise) begin e_press[c] = 1; m_pressed[c] = 1; m_ticks[c] = 0; end
        end else if (fall) begin
          e_rel[c] = 1;
          if (m_ticks[c] < LMS) e_short[c] = 1;
          m_pressed[c] = 0;
        end else if (tick) begin
          m_ticks[c]++;
          if (m_ticks[c] == LMS) e_long[c] = 1;
`ifdef AUTO_REPEAT_EN
          else if (m_ticks[c] > LMS && (m_ticks[c] - LMS) % RMS == 0) e_rep[c] = 1;
`endif
        end
        e_held[c] = m_pressed[c] && (m_ticks[c] >= LMS);
      end
      m_prev  = btn_in;
      m_armed = 1;
    end
    #1;
    chk("press_pulse",   press_pulse,   e_press);
    chk("short_pulse",   short_pulse,   e_short);
    chk("long_pulse",    long_pulse,    e_long);
    chk("release_pulse", release_pulse, e_rel);
    chk("repeat_pulse",  repeat_pulse,  e_rep);
    chk("held",          held,          e_held);
    chk("any_press",     any_press,     |e_press);
    for (int c = 0; c < NB; c++) begin
      n_press[c] += press_pulse[c];   n_short[c] += short_pulse[c];
      n_long[c]  += long_pulse[c];    n_rel[c]   += release_pulse[c];
      n_rep[c]   += repeat_pulse[c];
    end
  end

  task automatic clr();
    for (int c = 0; c < NB; c++) begin
      n_press[c] = 0; n_short[c] = 0; n_long[c] = 0; n_rel[c] = 0; n_rep[c] = 0;
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stop at a negedge whose following edge has prescaler phase ph
  task automatic align(input int ph);
    while ((cyc + 1) % DIV != ph) @(negedge clk);
  endtask

  initial begin
    clr();
    // Reset with button 2 already held
    btn_in = 5'b00100;
    wait_neg(3);
    chk("reset_outputs", {press_pulse, short_pulse, long_pulse, release_pulse, repeat_pulse, held, any_press}, 0);
    reset_n = 1'b1;
    wait_neg(6);
    chk("held_through_reset_press", n_press[2], 0);
    btn_in[2] = 1'b0; wait_neg(3);
    btn_in[2] = 1'b1; wait_neg(3);
    btn_in[2] = 1'b0; wait_neg(3);
    chk("repress_count", n_press[2], 1);

    // Short press on button 0
    clr();
    btn_in[0] = 1'b1;
    @(posedge clk); #1;
    chk("press_latency", {press_pulse, any_press}, {5'b00001, 1'b1});
    wait_neg(20);
    btn_in[0] = 1'b0;
    @(posedge clk); #1;
    chk("short_with_release", {short_pulse[0], release_pulse[0], long_pulse[0]}, 3'b110);
    wait_neg(3);
    chk("short_no_long", n_long[0], 0);

    // Long hold on button 1; the 5th tick comes 49 edges after the press edge
    clr();
    align(1);
    btn_in[1] = 1'b1;
    wait_neg(49);
    chk("long_not_yet", n_long[1], 0);
    wait_neg(1);
    chk("long_on_5th_tick", n_long[1], 1);
    wait_neg(70);
    chk("held_level", held, 5'b00010);
`ifdef AUTO_REPEAT_EN
    chk("repeat_count", n_rep[1], 3);
`else
    chk("repeat_count", n_rep[1], 0);
`endif
    btn_in[1] = 1'b0;
    @(posedge clk); #1;
    chk("held_release", {release_pulse, short_pulse}, {5'b00010, 5'b00000});
    wait_neg(3);

    // Fall coincident with the 5th tick: short wins
    align(1);
    btn_in[3] = 1'b1;
    wait_neg(49);
    btn_in[3] = 1'b0;
    @(posedge clk); #1;
    chk("fall_vs_long", {short_pulse[3], long_pulse[3], release_pulse[3]}, 3'b101);
    wait_neg(3);
    btn_in[0] = 1'b1; btn_in[3] = 1'b1;
    @(posedge clk); #1;
    chk("dual_press", {press_pulse, any_press}, {5'b01001, 1'b1});
    wait_neg(5);
    btn_in[0] = 1'b0; btn_in[3] = 1'b0;
    wait_neg(3);

    // Disable mid-hold
    btn_in[4] = 1'b1;
    wait_neg(60);
    chk("held_before_disable", held[4], 1'b1);
    clr();
    enable = 1'b0;
    @(posedge clk); #1;
    chk("held_drops", held, 5'b00000);
    wait_neg(20);
    enable = 1'b1;
    wait_neg(60);
    btn_in[4] = 1'b0;
    wait_neg(5);
    chk("disable_silent", n_press[4] + n_short[4] + n_long[4] + n_rel[4] + n_rep[4], 0);

    // Reset mid-hold
    btn_in[1] = 1'b1;
    wait_neg(60);
    clr();
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset", {press_pulse, short_pulse, long_pulse, release_pulse, repeat_pulse, held, any_press}, 0);
    wait_neg(2);
    reset_n = 1'b1;
    wait_neg(10);
    btn_in[1] = 1'b0;
    wait_neg(5);
    chk("no_release_after_reset", n_rel[1] + n_press[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
